pe_vec_mac: RTL and testbench

- Next-generation vector processing element for the systolic matrix-multiply array. Lane count is fully parametrised; no hardcoded lane list.
- One scalar B operand is broadcast to all VECTOR lanes.
- Two modes, selected per beat:
  - CHAIN: weight/pass-through. Per lane, c_out = a*b + c_in, as in the existing PE.
  - ACC: output-stationary. Per-lane local accumulators are read out by a drain command.
- Adds over the existing PE: valid qualification, signed wide accumulation, optional saturation, a 2-stage pipeline, and a sticky overflow flag.

---
 rtl/pe_pkg.sv | 45 ++++
 rtl/pe_vec_mac_if.sv | 31 +++
 rtl/pe_lane_mac.sv | 76 +++++++
 rtl/pe_vec_mac.sv | 98 +++++++++
 tb/tb_pe_vec_mac.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared types, default widths and the result-fitting helpers for the vector PE.
package pe_pkg;

  localparam int PE_REG_WIDTH = 16;
  localparam int PE_VECTOR    = 8;
  localparam int PE_ACC_WIDTH = 40;
  // Working width of the fit helpers; accumulators must not exceed it.
  localparam int PE_FIT_W     = 64;

  typedef enum logic {
    PE_CHAIN = 1'b0,
    PE_ACC   = 1'b1
  } pe_mode_e;

  // Largest value representable in a signed rw-bit field.
  function automatic logic signed [PE_FIT_W-1:0] fit_hi(input int rw);
    return (64'sd1 <<< (rw - 1)) - 64'sd1;
  endfunction

  // True when x does not fit a signed rw-bit field.
  function automatic logic fit_out_of_range(input logic signed [PE_FIT_W-1:0] x,
                                            input int rw);
    logic signed [PE_FIT_W-1:0] hi;
    logic signed [PE_FIT_W-1:0] lo;
    hi = fit_hi(rw);
    lo = -hi - 64'sd1;
    return (x > hi) || (x < lo);
  endfunction

  // Clamp x to the signed rw-bit range when sat is set; otherwise pass it
  // through so the caller's truncation keeps the low rw bits.
  function automatic logic signed [PE_FIT_W-1:0] sat_fit(input logic signed [PE_FIT_W-1:0] x,
                                                         input int rw,
                                                         input bit sat);
    logic signed [PE_FIT_W-1:0] hi;
    logic signed [PE_FIT_W-1:0] lo;
    hi = fit_hi(rw);
    lo = -hi - 64'sd1;
    if (!sat)   return x;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pe_vec_mac_if.sv
// Beat/result bundle of the vector PE; master drives beats, slave is the PE.
interface pe_vec_mac_if
  import pe_pkg::*;
#(
  parameter int REG_WIDTH = PE_REG_WIDTH,
  parameter int VECTOR    = PE_VECTOR
);
  logic                             in_valid;
  pe_mode_e                         mode;
  logic                             acc_clear;
  logic                             drain;
  logic [VECTOR-1:0][REG_WIDTH-1:0] a_in;
  logic [REG_WIDTH-1:0]             b_in;
  logic [VECTOR-1:0][REG_WIDTH-1:0] c_in;
  logic [VECTOR-1:0][REG_WIDTH-1:0] a_out;
  logic [REG_WIDTH-1:0]             b_out;
  logic                             b_valid_out;
  logic [VECTOR-1:0][REG_WIDTH-1:0] c_out;
  logic                             out_valid;
  logic                             ovf;

  modport master (
    output in_valid, mode, acc_clear, drain, a_in, b_in, c_in,
    input  a_out, b_out, b_valid_out, c_out, out_valid, ovf
  );

  modport slave (
    input  in_valid, mode, acc_clear, drain, a_in, b_in, c_in,
    output a_out, b_out, b_valid_out, c_out, out_valid, ovf
  );
endinterface

// File: rtl/pe_lane_mac.sv
// One lane: stage-1 signed multiply, stage-2 chain add / accumulate / drain and fit.
module pe_lane_mac
  import pe_pkg::*;
#(
  parameter int REG_WIDTH = PE_REG_WIDTH,
  parameter int ACC_WIDTH = PE_ACC_WIDTH,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  input  logic [REG_WIDTH-1:0] c,
  input  logic                 s1_valid,
  input  pe_mode_e             s1_mode,
  input  logic                 s1_clear,
  input  logic                 s1_drain,
  output logic [REG_WIDTH-1:0] c_out,
  output logic                 fit_ovf,
  output logic                 acc_wrap
);
  logic signed [2*REG_WIDTH-1:0] p_reg;
  logic signed [REG_WIDTH-1:0]   c_reg;
  logic signed [ACC_WIDTH-1:0]   acc_reg;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic signed [ACC_WIDTH-1:0]   p_ext;
  logic signed [ACC_WIDTH-1:0]   c_ext;
  logic signed [ACC_WIDTH-1:0]   base;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic signed [ACC_WIDTH-1:0]   out_val;
  logic                          acc_beat;
  logic                          chain_beat;
  logic                          emit;

  // Stage 1: product and upstream partial sum, captured every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= '0;
      c_reg <= '0;
    end else begin
      p_reg <= $signed(a) * $signed(b);
      c_reg <= $signed(c);
    end
  end

  // Stage 2 datapath: a drain wins over a chain beat; clear only changes the base.
  always_comb begin
    p_ext      = ACC_WIDTH'(p_reg);
    c_ext      = ACC_WIDTH'(c_reg);
    base       = s1_clear ? '0 : acc_reg;
    acc_beat   = s1_valid && (s1_mode == PE_ACC);
    chain_beat = s1_valid && (s1_mode == PE_CHAIN);
    acc_sum    = base + (acc_beat ? p_ext : '0);
    emit       = s1_drain || chain_beat;
    out_val    = s1_drain ? acc_sum : (p_ext + c_ext);
    fit_ovf    = emit && fit_out_of_range(PE_FIT_W'(out_val), REG_WIDTH);
    acc_wrap   = acc_beat && (base[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1])
                          && (acc_sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    acc_next   = acc_reg;
    if (s1_drain)      acc_next = '0;
    else if (acc_beat) acc_next = acc_sum;
    else if (s1_clear) acc_next = '0;
  end

  // Stage 2 state: accumulator update and result register (holds when idle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      c_out   <= '0;
    end else begin
      acc_reg <= acc_next;
      if (emit) c_out <= REG_WIDTH'(sat_fit(PE_FIT_W'(out_val), REG_WIDTH, SATURATE));
    end
  end

endmodule

// File: rtl/pe_vec_mac.sv
// Vector PE: neighbour forwarding, beat-flag pipeline, per-lane MACs and sticky overflow.
module pe_vec_mac
  import pe_pkg::*;
#(
  parameter int REG_WIDTH = PE_REG_WIDTH,
  parameter int VECTOR    = PE_VECTOR,
  parameter int ACC_WIDTH = PE_ACC_WIDTH,
  parameter bit SATURATE  = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  pe_vec_mac_if.slave bus
);
  logic                             s1_valid;
  pe_mode_e                         s1_mode;
  logic                             s1_clear;
  logic                             s1_drain;
  logic [VECTOR-1:0][REG_WIDTH-1:0] lane_c;
  logic [VECTOR-1:0]                lane_ovf;
  logic [VECTOR-1:0]                lane_wrap;

  if (VECTOR < 1 || ACC_WIDTH < 2*REG_WIDTH+1 || ACC_WIDTH > PE_FIT_W) begin : g_param_check
    $error("pe_vec_mac: illegal VECTOR/REG_WIDTH/ACC_WIDTH combination");
  end

  // Forward operands to the neighbour; data only moves on a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.a_out       <= '0;
      bus.b_out       <= '0;
      bus.b_valid_out <= 1'b0;
    end else begin
      bus.b_valid_out <= bus.in_valid;
      if (bus.in_valid) begin
        bus.a_out <= bus.a_in;
        bus.b_out <= bus.b_in;
      end
    end
  end

  // Beat control travels alongside the stage-1 products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= PE_CHAIN;
      s1_clear <= 1'b0;
      s1_drain <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_mode  <= bus.mode;
      s1_clear <= bus.acc_clear;
      s1_drain <= bus.drain;
    end
  end

  for (genvar gi = 0; gi < VECTOR; gi++) begin : g_lane
    pe_lane_mac #(
      .REG_WIDTH (REG_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SATURATE  (SATURATE)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (bus.a_in[gi]),
      .b        (bus.b_in),
      .c        (bus.c_in[gi]),
      .s1_valid (s1_valid),
      .s1_mode  (s1_mode),
      .s1_clear (s1_clear),
      .s1_drain (s1_drain),
      .c_out    (lane_c[gi]),
      .fit_ovf  (lane_ovf[gi]),
      .acc_wrap (lane_wrap[gi])
    );
  end

  assign bus.c_out = lane_c;

  // Result qualifier and sticky overflow; clear drops old history but a
  // same-cycle out-of-range drain still sets the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.out_valid <= s1_drain || (s1_valid && (s1_mode == PE_CHAIN));
      bus.ovf       <= (s1_clear ? 1'b0 : bus.ovf) | (|lane_ovf);
    end
  end

  a_no_drain_with_chain : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.drain && bus.in_valid && (bus.mode == PE_CHAIN)))
    else $error("drain issued together with a CHAIN beat");

  a_no_acc_wrap : assert property (@(posedge clk) disable iff (!rst_n) !(|lane_wrap))
    else $error("accumulator wrapped");

endmodule

// File: tb/tb_pe_vec_mac.sv
// Scoreboard bench for pe_vec_mac: directed cases then random beats vs. a plain-arithmetic model.
module tb_pe_vec_mac;
  import pe_pkg::*;

  localparam int RW  = 16;
  localparam int V   = 8;
  localparam int AW  = 40;
  localparam bit SAT = 1'b1;

  typedef logic [V-1:0][RW-1:0] vec_t;
  typedef struct {
    vec_t c;
    bit   ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_vec_mac_if #(.REG_WIDTH(RW), .VECTOR(V)) bus ();

  pe_vec_mac #(.REG_WIDTH(RW), .VECTOR(V), .ACC_WIDTH(AW), .SATURATE(SAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t          sb[$];
  longint        acc_m[V];
  bit            ovf_m;
  vec_t          fwd_a;
  logic [RW-1:0] fwd_b;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Fit a mathematical result into RW signed bits, noting overflow.
  function automatic logic [RW-1:0] fit_m(input longint x, inout bit o);
    longint hi, lo, y;
    hi = (longint'(1) << (RW - 1)) - 1;
    lo = -hi - 1;
    y  = x;
    if (x > hi || x < lo) o = 1'b1;
    if (SAT) begin
      if (x > hi) y = hi;
      if (x < lo) y = lo;
    end
    return y[RW-1:0];
  endfunction

  // Reference behaviour of one input cycle; pushes the expected output if any.
  task automatic model(input bit v, input pe_mode_e m, input bit clr, input bit drn,
                       input vec_t a, input logic [RW-1:0] b, input vec_t c);
    exp_t   e;
    bit     emit = 1'b0;
    bit     accb;
    longint p, base;
    e.c  = '0;
    accb = v && (m == PE_ACC);
    if (clr) ovf_m = 1'b0;
    for (int i = 0; i < V; i++) begin
      p    = longint'($signed(a[i])) * longint'($signed(b));
      base = clr ? 0 : acc_m[i];
      if (drn) begin
        e.c[i]   = fit_m(base + (accb ? p : 0), ovf_m);
        acc_m[i] = 0;
        emit     = 1'b1;
      end else begin
        if (v && m == PE_CHAIN) begin
          e.c[i] = fit_m(p + longint'($signed(c[i])), ovf_m);
          emit   = 1'b1;
        end
        if (accb)     acc_m[i] = base + p;
        else if (clr) acc_m[i] = 0;
      end
    end
    e.ovf = ovf_m;
    if (emit) sb.push_back(e);
  endtask

  // Drive one cycle, update the model, then check forwarding after the edge.
  task automatic step(input bit v, input pe_mode_e m, input bit clr, input bit drn,
                      input vec_t a, input logic [RW-1:0] b, input vec_t c);
    bus.in_valid  = v;
    bus.mode      = m;
    bus.acc_clear = clr;
    bus.drain     = drn;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.c_in      = c;
    model(v, m, clr, drn, a, b, c);
    if (v) begin
      fwd_a = a;
      fwd_b = b;
    end
    @(posedge clk);
    #1;
    chk("b_valid_out", bus.b_valid_out, v);
    chk("a_out", bus.a_out, fwd_a);
    chk("b_out", bus.b_out, fwd_b);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, PE_CHAIN, 1'b0, 1'b0, '0, '0, '0);
  endtask

  function automatic vec_t splat(input logic [RW-1:0] x);
    vec_t r;
    for (int i = 0; i < V; i++) r[i] = x;
    return r;
  endfunction

  function automatic vec_t ramp(input int k);
    vec_t r;
    for (int i = 0; i < V; i++) r[i] = RW'(i + k);
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      default: return RW'($urandom);
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int i = 0; i < V; i++) r[i] = rand_val();
    return r;
  endfunction

  // Asynchronous reset mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.acc_clear = 1'b0;
    bus.drain     = 1'b0;
    #2;
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < V; i++) acc_m[i] = 0;
    ovf_m = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    #1;
    chk("rst_c_out", bus.c_out, '0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_a_out", bus.a_out, '0);
    chk("rst_b_out", bus.b_out, '0);
    chk("rst_b_valid_out", bus.b_valid_out, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every out_valid must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out_valid actual=1 required=0");
      end else begin
        e = sb.pop_front();
        chk("c_out", bus.c_out, e.c);
        chk("ovf", bus.ovf, e.ovf);
      end
    end
  end

  initial begin : stimulus
    vec_t     a, c, z;
    pe_mode_e m;
    bit       v, clr, drn;
    z = '0;
    bus.in_valid  = 1'b0;
    bus.mode      = PE_CHAIN;
    bus.acc_clear = 1'b0;
    bus.drain     = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.c_in      = '0;
    @(posedge clk);
    #1;
    do_reset();
    idle(1);

    // CHAIN on lane 0: 3 * -4 + 5 = -7
    a = z; a[0] = 16'd3;
    c = z; c[0] = 16'd5;
    step(1'b1, PE_CHAIN, 1'b0, 1'b0, a, 16'hFFFC, c);
    idle(3);

    // Saturation on all lanes, then clear alone resets the sticky flag
    step(1'b1, PE_CHAIN, 1'b0, 1'b0, splat(16'h7FFF), 16'h7FFF, z);
    step(1'b0, PE_CHAIN, 1'b1, 1'b0, z, '0, z);
    idle(2);
    chk("ovf_after_clear", bus.ovf, ovf_m);

    // Four ACC beats then two drains
    for (int k = 0; k < 4; k++) step(1'b1, PE_ACC, 1'b0, 1'b0, ramp(1), 16'd2, z);
    step(1'b0, PE_CHAIN, 1'b0, 1'b1, z, '0, z);
    step(1'b0, PE_CHAIN, 1'b0, 1'b1, z, '0, z);
    idle(3);

    // acc=100, then ACC beat with clear, drain; then ACC beat with drain
    step(1'b1, PE_ACC, 1'b0, 1'b0, splat(16'd100), 16'd1, z);
    step(1'b1, PE_ACC, 1'b1, 1'b0, splat(16'd1), 16'd5, z);
    step(1'b0, PE_CHAIN, 1'b0, 1'b1, z, '0, z);
    step(1'b1, PE_ACC, 1'b0, 1'b1, splat(16'd2), 16'd3, z);
    idle(3);

    // Reset between accumulation beats
    step(1'b1, PE_ACC, 1'b0, 1'b0, ramp(3), 16'd7, z);
    step(1'b1, PE_ACC, 1'b0, 1'b0, ramp(5), 16'd9, z);
    do_reset();
    step(1'b1, PE_ACC, 1'b0, 1'b0, ramp(2), 16'd4, z);
    step(1'b0, PE_CHAIN, 1'b0, 1'b1, z, '0, z);
    idle(3);

    // Interleaved modes: outputs 5, 4, then drained 1
    step(1'b1, PE_CHAIN, 1'b0, 1'b0, splat(16'd2), 16'd2, splat(16'd1));
    step(1'b1, PE_ACC, 1'b0, 1'b0, splat(16'd1), 16'd1, splat(16'd3));
    step(1'b1, PE_CHAIN, 1'b0, 1'b0, splat(16'd0), 16'd9, splat(16'd4));
    step(1'b0, PE_CHAIN, 1'b0, 1'b1, z, '0, z);
    idle(3);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      v   = ($urandom_range(0, 3) != 0);
      m   = pe_mode_e'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      drn = ($urandom_range(0, 7) == 0);
      if (drn && v && m == PE_CHAIN) m = PE_ACC;
      step(v, m, clr, drn, rand_vec(), rand_val(), rand_vec());
    end
    idle(4);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
